snake_body_ctrl: RTL and testbench
==================================

Name: snake_body_ctrl

Overview:
Snake movement and body-tracking stage, directly upstream of the apple-eating logic. It produces the snake head position consumed by the apple module, consumes that module's add_cube grow request, and keeps the body as a shift-register of segment coordinates. It also detects wall and self collisions, and answers registered per-pixel body queries for the display stage.

Parameters:
MOVE_TICKS, 12_500_000, CLK_50M cycles between snake steps (0.25 s).
MAX_LEN, 16, maximum number of segments, including the head.
INIT_LEN, 3, segment count after reset.
GRID_W, 40, grid columns; x runs 0..39 and columns 0 and 39 are wall.
GRID_H, 30, grid rows; y runs 0..29 and rows 0 and 29 are wall.

Ports:
CLK_50M  in  1  system clock, 50 MHz.
RSTn  in  1  reset, asynchronous, active-low.
key_up, key_down, key_left, key_right  in  1 each  debounced single-cycle direction pulses.
add_cube  in  1  grow request from the apple stage; a level signal that may stay high for many cycles.
pix_x  in  6  display query column.
pix_y  in  6  display query row.
head_x  out  6  current head column.
head_y  out  6  current head row; bit 5 is always 0.
body_len  out  5  current segment count.
seg_hit  out  1  registered: (pix_x, pix_y) matches an active segment.
game_over  out  1  high in DEAD.
running  out  1  high in RUN.

Behaviour:
- One clock. All state resets asynchronously on RSTn low.
- Reset values:
  - head_x=20, head_y=15.
  - seg[1]=(19,15), seg[2]=(18,15); other segments are (0,0) and inactive.
  - body_len=INIT_LEN, dir=RIGHT, state=IDLE.
  - seg_hit=0, game_over=0, running=0, grow_pend=0, tick counter=0.
- Reset mid-game returns to the reset values immediately. No partial move completes.
- FSM states:
  - IDLE: any key pulse -> RUN. A pulse that is not the reverse of RIGHT also sets dir; LEFT is ignored as a reverse.
  - RUN: steps on each move tick. A collision -> DEAD.
  - DEAD: stays in DEAD until reset. Keys are ignored.
- Tick counter:
  - Counts only in RUN.
  - tick=1 for one cycle when the count reaches MOVE_TICKS-1, then the count wraps to 0.
- Direction:
  - A key pulse loads next_dir, unless it is the exact reverse of the dir last applied on a step. Reverse pulses are ignored.
  - next_dir is copied to dir on tick. The last valid pulse before a tick wins.
  - Simultaneous key pulses: priority up > down > left > right.
- Grow request:
  - A rising edge of add_cube (registered previous value) sets grow_pend.
  - A held-high add_cube gives exactly one growth.
  - grow_pend clears on the next step that consumes it.
- Step, on tick in RUN:
  - nh = seg[0] offset by one cell in dir.
  - Wall collision: nh.x==0, nh.x==GRID_W-1, nh.y==0 or nh.y==GRID_H-1.
  - Self collision: nh equals seg[i] for i < body_len-1 when not growing, or i < body_len when growing. The vacating tail does not count.
  - On any collision: go to DEAD. Segments and body_len are unchanged, so the head stays on its last legal cell.
  - Otherwise: seg[i] <= seg[i-1] for i >= 1, and seg[0] <= nh.
  - If grow_pend and body_len < MAX_LEN: body_len increments and the old tail stays valid.
  - At MAX_LEN, grow_pend clears and the length is unchanged.
- head_x/head_y mirror seg[0], so they update in the same cycle as the step.
- seg_hit: one-cycle latency. It is 1 when any i < body_len has seg[i]==(pix_x,pix_y). It is valid in every state.
- Coordinate arithmetic is 6-bit unsigned. A wrap cannot occur because walls stop the head first.

Decomposition:
- Package snake_pkg holds:
  - GRID_W, GRID_H, and the reset head coordinates.
  - Direction encoding UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - State encoding IDLE, RUN, DEAD.
  - The is_reverse(a,b) function.
- Sub-module snake_tick_gen (parameter MOVE_TICKS; ports: enable in, tick out) holds the step counter.
- The segment array, FSM, collision compare and query logic stay in snake_body_ctrl.

Test Plan:
- Reset, then key_up pulse, with MOVE_TICKS=4 for simulation -> running=1; after one tick, head=(20,14), seg[1]=(20,15), body_len=3.
- In RUN heading RIGHT, pulse key_left -> ignored; next tick head_x goes 20->21, dir unchanged.
- Hold add_cube high for 10 ticks -> body_len goes 3->4 exactly once; the tail cell is retained on that step only.
- Steer RIGHT from (20,15) -> after 18 ticks head=(38,15); next tick game_over=1, head stays (38,15), later ticks change nothing.
- Grow to length 5, then turn up, left, down into the body -> game_over=1 on the step that hits seg[i]. A move into the vacating tail cell at length 4 without growth does not die.
- Query pix=(19,15) right after reset -> seg_hit=1 one cycle later; pix=(25,15) -> 0. At MAX_LEN=16, a further add_cube edge leaves body_len=16.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid constants, encodings and helpers for the snake body stage
package snake_pkg;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;

  localparam logic [5:0] HEAD_X0 = 6'd20;
  localparam logic [5:0] HEAD_Y0 = 6'd15;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
  } coord_t;

  // Opposite directions differ only in bit 0 with this encoding.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b01;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// rtl/snake_tick_gen.sv - move-step strobe generator, counts only while enabled
module snake_tick_gen #(
  parameter int MOVE_TICKS = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_TICKS - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (enable) begin
      if (count_q == LAST) begin
        tick    = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// rtl/snake_body_ctrl.sv - snake movement FSM, segment shift register, collisions and pixel query
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int MOVE_TICKS = 12_500_000,
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3
) (
  input  logic       CLK_50M,
  input  logic       RSTn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       add_cube,
  input  logic [5:0] pix_x,
  input  logic [5:0] pix_y,
  output logic [5:0] head_x,
  output logic [5:0] head_y,
  output logic [4:0] body_len,
  output logic       seg_hit,
  output logic       game_over,
  output logic       running
);

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  dir_t       next_dir_q, next_dir_d;
  logic       add_q;
  logic       grow_pend_q, grow_pend_d;
  logic [4:0] len_q, len_d;
  logic       seg_hit_q, seg_hit_d;
  coord_t     seg_q [MAX_LEN];
  coord_t     seg_d [MAX_LEN];

  logic       run_en;
  logic       tick;
  logic       key_any;
  dir_t       key_dir;
  dir_t       applied_dir;
  coord_t     nh;
  logic       wall_hit;
  logic       self_hit;
  logic       growing;
  logic [4:0] hit_lim;
  logic       add_rise;

  assign run_en = (state_q == ST_RUN);

  snake_tick_gen #(
    .MOVE_TICKS(MOVE_TICKS)
  ) u_tick_gen (
    .clk   (CLK_50M),
    .rst_n (RSTn),
    .enable(run_en),
    .tick  (tick)
  );

  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    key_dir = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
  end

  // A key landing on a step cycle is judged against the direction that step applies.
  assign applied_dir = tick ? next_dir_q : dir_q;

  always_comb begin
    nh = seg_q[0];
    case (next_dir_q)
      DIR_UP:    nh.y = seg_q[0].y - 6'd1;
      DIR_DOWN:  nh.y = seg_q[0].y + 6'd1;
      DIR_LEFT:  nh.x = seg_q[0].x - 6'd1;
      DIR_RIGHT: nh.x = seg_q[0].x + 6'd1;
      default:   nh = seg_q[0];
    endcase

    wall_hit = (nh.x == 6'd0) || (nh.x == 6'(GRID_W - 1)) ||
               (nh.y == 6'd0) || (nh.y == 6'(GRID_H - 1));

    // Without growth the tail cell vacates on this step, so it is excluded.
    growing = grow_pend_q && (len_q < 5'(MAX_LEN));
    hit_lim = growing ? len_q : (len_q - 5'd1);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < hit_lim) && (seg_q[i] == nh)) self_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    next_dir_d  = next_dir_q;
    grow_pend_d = grow_pend_q;
    len_d       = len_q;
    seg_d       = seg_q;
    add_rise    = add_cube & ~add_q;

    case (state_q)
      ST_IDLE: begin
        if (key_any) begin
          state_d = ST_RUN;
          if (!is_reverse(key_dir, dir_q)) begin
            dir_d      = key_dir;
            next_dir_d = key_dir;
          end
        end
      end
      ST_RUN: begin
        if (tick) begin
          dir_d = next_dir_q;
          if (wall_hit || self_hit) begin
            state_d = ST_DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
            seg_d[0]    = nh;
            grow_pend_d = 1'b0;
            if (growing) len_d = len_q + 5'd1;
          end
        end
        if (key_any && !is_reverse(key_dir, applied_dir)) next_dir_d = key_dir;
      end
      default: ;
    endcase

    if (add_rise) grow_pend_d = 1'b1;
  end

  always_comb begin
    seg_hit_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (seg_q[i].x == pix_x) && (seg_q[i].y == pix_y)) seg_hit_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      add_q       <= 1'b0;
      grow_pend_q <= 1'b0;
      len_q       <= 5'(INIT_LEN);
      seg_hit_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          seg_q[i].x <= HEAD_X0 - 6'(i);
          seg_q[i].y <= HEAD_Y0;
        end else begin
          seg_q[i].x <= 6'd0;
          seg_q[i].y <= 6'd0;
        end
      end
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      next_dir_q  <= next_dir_d;
      add_q       <= add_cube;
      grow_pend_q <= grow_pend_d;
      len_q       <= len_d;
      seg_hit_q   <= seg_hit_d;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign head_x    = seg_q[0].x;
  assign head_y    = seg_q[0].y;
  assign body_len  = len_q;
  assign seg_hit   = seg_hit_q;
  assign game_over = (state_q == ST_DEAD);
  assign running   = (state_q == ST_RUN);

endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb/tb_snake_body_ctrl.sv - directed self-checking bench for snake_body_ctrl
module tb_snake_body_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_up, key_down, key_left, key_right;
  logic       add_cube;
  logic [5:0] pix_x, pix_y;
  logic [5:0] head_x, head_y;
  logic [4:0] body_len;
  logic       seg_hit, game_over, running;

  int vectors = 0;
  int miscompares = 0;
  int ph = 0;

  always #5 clk = ~clk;

  snake_body_ctrl #(
    .MOVE_TICKS(4),
    .MAX_LEN   (16),
    .INIT_LEN  (3)
  ) dut (
    .CLK_50M  (clk),
    .RSTn     (rst_n),
    .key_up   (key_up),
    .key_down (key_down),
    .key_left (key_left),
    .key_right(key_right),
    .add_cube (add_cube),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .head_x   (head_x),
    .head_y   (head_y),
    .body_len (body_len),
    .seg_hit  (seg_hit),
    .game_over(game_over),
    .running  (running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ph counts cycles since the last step; it returns to 0 right after each step edge.
  task automatic cyc();
    @(negedge clk);
    ph = (ph + 1) % 4;
  endtask

  task automatic next_step();
    do cyc(); while (ph != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {key_up, key_down, key_left, key_right} = 4'b0;
    add_cube = 1'b0;
    pix_x = 6'd0;
    pix_y = 6'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ph = 0;
  endtask

  task automatic pulse(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
    cyc();
    {key_up, key_down, key_left, key_right} = 4'b0;
  endtask

  task automatic start(input logic [3:0] k);
    pulse(k);
    ph = 0;
  endtask

  task automatic query(input string tag, input int x, input int y, input logic exp);
    pix_x = 6'(x);
    pix_y = 6'(y);
    cyc();
    chk(tag, seg_hit, exp);
  endtask

  task automatic chk_head(input string tag, input int x, input int y);
    chk({tag, "_x"}, head_x, x);
    chk({tag, "_y"}, head_y, y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and initial body query
    do_reset();
    chk_head("rst_head", 20, 15);
    chk("rst_len", body_len, 3);
    chk("rst_running", running, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_seg_hit_origin", seg_hit, 0);
    query("q_seg1", 19, 15, 1'b1);
    query("q_off", 25, 15, 1'b0);
    query("q_tail", 18, 15, 1'b0 | 1'b1);
    query("q_past_tail", 17, 15, 1'b0);

    // key_up from IDLE: run, then one step upward
    start(4'b1000);
    chk("up_running", running, 1);
    chk_head("up_prestep", 20, 15);
    next_step();
    chk_head("up_step", 20, 14);
    chk("up_len", body_len, 3);
    query("up_q_seg1", 20, 15, 1'b1);
    query("up_q_seg2", 19, 15, 1'b1);
    query("up_q_old_tail", 18, 15, 1'b0);

    // LEFT is a reverse of RIGHT both in IDLE and in RUN
    do_reset();
    start(4'b0010);
    chk("left_idle_running", running, 1);
    next_step();
    chk_head("left_idle_step", 21, 15);
    pulse(4'b0010);
    next_step();
    chk_head("left_run_step", 22, 15);

    // Held add_cube gives exactly one growth, tail kept on that step only
    add_cube = 1'b1;
    next_step();
    chk_head("grow_step1", 23, 15);
    chk("grow_len1", body_len, 4);
    query("grow_q_tail_kept", 20, 15, 1'b1);
    query("grow_q_beyond", 19, 15, 1'b0);
    repeat (9) next_step();
    add_cube = 1'b0;
    chk_head("grow_step10", 32, 15);
    chk("grow_len10", body_len, 4);
    query("grow_q_tail", 29, 15, 1'b1);
    query("grow_q_dropped", 28, 15, 1'b0);

    // Simultaneous down+left: down has priority
    do_reset();
    start(4'b0110);
    next_step();
    chk_head("prio_step", 20, 16);

    // Wall at column 39
    do_reset();
    start(4'b0001);
    repeat (18) next_step();
    chk_head("wall_pre", 38, 15);
    chk("wall_pre_go", game_over, 0);
    next_step();
    chk("wall_go", game_over, 1);
    chk("wall_running", running, 0);
    chk_head("wall_hold", 38, 15);
    chk("wall_len", body_len, 3);
    pulse(4'b1000);
    repeat (8) cyc();
    chk_head("dead_hold", 38, 15);
    chk("dead_go", game_over, 1);
    query("dead_q_seg1", 37, 15, 1'b1);
    query("dead_q_off", 35, 15, 1'b0);

    // Grow to 5 and turn into the body
    do_reset();
    start(4'b0001);
    add_cube = 1'b1;
    next_step();
    add_cube = 1'b0;
    cyc();
    add_cube = 1'b1;
    next_step();
    add_cube = 1'b0;
    chk("self_len5", body_len, 5);
    chk_head("self_h0", 22, 15);
    pulse(4'b1000);
    next_step();
    chk_head("self_h1", 22, 14);
    pulse(4'b0010);
    next_step();
    chk_head("self_h2", 21, 14);
    chk("self_pre_go", game_over, 0);
    pulse(4'b0100);
    next_step();
    chk("self_go", game_over, 1);
    chk_head("self_hold", 21, 14);
    chk("self_len_hold", body_len, 5);

    // Length 4, no growth: moving into the vacating tail is legal
    do_reset();
    start(4'b0001);
    add_cube = 1'b1;
    next_step();
    add_cube = 1'b0;
    chk("tail_len4", body_len, 4);
    pulse(4'b1000);
    next_step();
    pulse(4'b0010);
    next_step();
    chk_head("tail_h2", 20, 14);
    pulse(4'b0100);
    next_step();
    chk_head("tail_h3", 20, 15);
    chk("tail_go3", game_over, 0);
    chk("tail_run3", running, 1);
    pulse(4'b0001);
    next_step();
    chk_head("tail_h4", 21, 15);
    chk("tail_go4", game_over, 0);

    // Grow to MAX_LEN, then one more edge leaves length at 16
    do_reset();
    start(4'b0001);
    repeat (13) begin
      add_cube = 1'b1;
      cyc();
      add_cube = 1'b0;
      next_step();
    end
    chk("max_len16", body_len, 16);
    chk_head("max_h13", 33, 15);
    add_cube = 1'b1;
    cyc();
    add_cube = 1'b0;
    next_step();
    chk("max_len_sat", body_len, 16);
    chk_head("max_h14", 34, 15);
    query("max_q_tail", 19, 15, 1'b1);
    query("max_q_dropped", 18, 15, 1'b0);

    // Asynchronous reset mid-game takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    chk_head("async_rst_head", 20, 15);
    chk("async_rst_len", body_len, 3);
    chk("async_rst_running", running, 0);
    chk("async_rst_go", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    query("post_rst_q_seg2", 18, 15, 1'b1);
    query("post_rst_q_off", 25, 15, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
